// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory, shared-ALU multicycle MIPS-subset datapath.
// Moore-style decode per state, memory-ready stalls with a bounded wait,
// trap on illegal opcode or memory timeout, and a retired-instruction counter.
module multicycle_controller #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             pc_en,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic             trapped,
   output logic             mem_timeout,
   output logic [3:0]       state
);

   // wait counter only ever reaches MAX_WAIT-1 before a trap or a state change
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_RWB      = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_TRAP     = 4'd10
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             timeout_q, timeout_d;
   ctrl_t            ctrl;
   logic             retire_raw;
   logic             mem_state;

   // state, wait counter, retire counter and sticky timeout flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   // next state; a stalled memory state escalates to TRAP once the wait budget is spent
   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      timeout_d = timeout_q;
      mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         // the instruction register still holds the opcode, so lw/sw split here
         S_MEMADDR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_EXECUTE:  state_d = S_RWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
      // ready wins: only a low mem_ready on the last tolerated cycle traps
      if (mem_state && !mem_ready) begin
         if (wait_q == WAIT_LAST) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
         end else begin
            wait_d = wait_q + WW'(1);
         end
      end
      count_d = count_q + CNT_W'(retire);
   end

   // per-state datapath control decode and retire pulse
   always_comb begin
      ctrl       = '0;
      retire_raw = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE:  ctrl.alu_src_b = 2'b11;
         S_MEMADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            retire_raw      = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            retire_raw     = mem_ready;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            retire_raw     = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = 2'b01;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            retire_raw         = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
            retire_raw     = 1'b1;
         end
         default: ;
      endcase
   end

   // everything the datapath sees is held low while reset is asserted
   assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource} = reset ? '0 : ctrl;
   assign retire      = !reset && retire_raw;
   assign pc_en       = PCWrite | (PCWriteCond & zero);
   assign trapped     = !reset && (state_q == S_TRAP);
   assign instr_count = count_q;
   assign mem_timeout = timeout_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed + randomized bench for multicycle_controller. Each instruction is
// expanded into its expected per-cycle state trace from the latency/stall
// rules, then driven cycle by cycle and compared.
module tb_multicycle_controller;

   localparam int CNT_W    = 4;   // narrow so the counter wrap is exercised
   localparam int MAX_WAIT = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [5:0]       opcode = 6'h00;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic             MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0]       ALUSrcB, ALUOp, PCSource;
   logic             pc_en, retire, trapped, mem_timeout;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       state;
   logic [15:0]      ctrl_obs;

   multicycle_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .pc_en(pc_en), .retire(retire), .instr_count(instr_count),
      .trapped(trapped), .mem_timeout(mem_timeout), .state(state)
   );

   assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int model_cnt = 0;

   typedef struct {
      int st;
      bit rdy;
      bit to;
   } ent_t;
   ent_t trace[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // control word expected from the per-state output table
   function automatic logic [15:0] exp_ctrl(input int st, input bit rdy);
      logic [15:0] c;
      c = '0;
      case (st)
         0:  begin c[12] = 1'b1; c[5:4] = 2'b01; c[15] = rdy; c[10] = rdy; end
         1:  c[5:4] = 2'b11;
         2:  begin c[6] = 1'b1; c[5:4] = 2'b10; end
         3:  begin c[12] = 1'b1; c[13] = 1'b1; end
         4:  begin c[8] = 1'b1; c[9] = 1'b1; end
         5:  begin c[11] = 1'b1; c[13] = 1'b1; end
         6:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
         7:  begin c[8] = 1'b1; c[7] = 1'b1; end
         8:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
         9:  begin c[15] = 1'b1; c[1:0] = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic push_plain(input int st);
      ent_t e;
      e.st = st; e.rdy = bit'($urandom_range(0, 1)); e.to = 1'b0;
      trace.push_back(e);
   endtask

   // memory stage: w low cycles then a ready cycle, or TRAP once the budget runs out
   task automatic push_mem(input int st, input int w, output bit tr);
      ent_t e;
      tr = 1'b0;
      for (int i = 0; i < w && i < MAX_WAIT; i++) begin
         e.st = st; e.rdy = 1'b0; e.to = 1'b0;
         trace.push_back(e);
      end
      if (w >= MAX_WAIT) begin
         e.st = 10; e.rdy = 1'b0; e.to = 1'b1;
         tr = 1'b1;
      end else begin
         e.st = st; e.rdy = 1'b1; e.to = 1'b0;
      end
      trace.push_back(e);
   endtask

   task automatic run_instr(input logic [5:0] op, input bit z, input int wf, input int wm);
      bit tr;
      bit exp_ret, exp_pc;
      trace.delete();
      push_mem(0, wf, tr);
      if (!tr) begin
         push_plain(1);
         case (op)
            6'h23: begin push_plain(2); push_mem(3, wm, tr); if (!tr) push_plain(4); end
            6'h2B: begin push_plain(2); push_mem(5, wm, tr); end
            6'h00: begin push_plain(6); push_plain(7); end
            6'h04: push_plain(8);
            6'h02: push_plain(9);
            default: push_plain(10);
         endcase
      end
      opcode = op;
      zero   = z;
      foreach (trace[i]) begin
         mem_ready = trace[i].rdy;
         @(negedge clk);
         exp_ret = (trace[i].st inside {4, 7, 8, 9}) || (trace[i].st == 5 && trace[i].rdy);
         exp_pc  = (trace[i].st == 9) || (trace[i].st == 0 && trace[i].rdy) ||
                   (trace[i].st == 8 && z);
         chk("state", 32'(state), 32'(trace[i].st));
         chk("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(trace[i].st, trace[i].rdy)));
         chk("retire", 32'(retire), 32'(exp_ret));
         chk("pc_en", 32'(pc_en), 32'(exp_pc));
         chk("trapped", 32'(trapped), 32'(trace[i].st == 10));
         chk("mem_timeout", 32'(mem_timeout), 32'(trace[i].to));
         if (exp_ret) model_cnt++;
         @(posedge clk); #1;
      end
      chk("instr_count", 32'(instr_count), 32'(model_cnt % (1 << CNT_W)));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctrl", 32'(ctrl_obs), 32'd0);
      chk("rst_outs", 32'({pc_en, retire, trapped, mem_timeout}), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_cnt = 0;
   endtask

   initial begin
      logic [5:0] ops [5];
      int k;
      ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00; ops[3] = 6'h04; ops[4] = 6'h02;

      #1 reset = 1'b1;
      @(posedge clk); #1;
      do_reset();

      // basic classes with no wait states
      run_instr(6'h23, 1'b0, 0, 0);
      run_instr(6'h2B, 1'b0, 0, 0);
      run_instr(6'h00, 1'b0, 0, 0);
      run_instr(6'h02, 1'b0, 0, 0);
      run_instr(6'h04, 1'b1, 0, 0);
      run_instr(6'h04, 1'b0, 0, 0);
      // stalls: 3 in FETCH, 2 in MEMREAD; then ready arriving on the last tolerated cycle
      run_instr(6'h23, 1'b0, 3, 2);
      run_instr(6'h2B, 1'b0, 0, MAX_WAIT - 1);
      run_instr(6'h23, 1'b1, MAX_WAIT - 1, 0);

      // random legal traffic, long enough to wrap the counter
      for (int n = 0; n < 30; n++) begin
         k = $urandom_range(0, 4);
         run_instr(ops[k], bit'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // memory timeout in MEMWRITE; TRAP must hold
      run_instr(6'h2B, 1'b0, 0, MAX_WAIT);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("trap_hold", 32'(state), 32'd10);
      chk("trap_sticky_to", 32'(mem_timeout), 32'd1);
      chk("trap_no_retire", 32'(retire), 32'd0);

      // illegal opcode
      do_reset();
      run_instr(6'h3F, 1'b0, 0, 0);

      // async reset in the middle of an R-type
      do_reset();
      run_instr(6'h02, 1'b0, 0, 0);
      opcode = 6'h00;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_pre_state", 32'(state), 32'd6);
      reset = 1'b1;
      #1;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_ctrl", 32'(ctrl_obs), 32'd0);
      chk("abort_retire", 32'(retire), 32'd0);
      chk("abort_count", 32'(instr_count), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-resource multicycle version of the team's MIPS-subset datapath.
- In that datapath one memory serves both instruction fetch and data access, and one ALU serves PC increment, address calculation, execute and branch compare.
- Decodes opcode per state and drives every datapath select/enable. Stalls on a memory-ready handshake, traps on illegal opcodes or memory timeout, and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MAX_WAIT, 8, max consecutive mem_ready-low cycles tolerated in one memory state before trap (>=1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears state and counters.
- opcode  input  6  instruction[31:26] from the instruction register, valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
- ALUSrcB  output  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded (to ALU_controller).
- PCSource  output  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- pc_en  output  1  PCWrite | (PCWriteCond & zero).
- retire  output  1  one-cycle pulse on the final cycle of each instruction.
- instr_count  output  CNT_W  retired instructions, wraps.
- trapped  output  1  FSM is in TRAP.
- mem_timeout  output  1  sticky; trap was caused by timeout.
- state  output  4  current state encoding (debug).

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RWB=7, BRANCH=8, JUMP=9, TRAP=10. Encodings 11-15 go to TRAP next cycle.
- Reset (async): state=FETCH, instr_count=0, wait_cnt=0, mem_timeout=0. While reset is high, every control output, pc_en, retire and trapped is forced 0. The first cycle after deassert is FETCH.
- Output decode per state (unlisted signals are 0):
  - FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWRITE: MemWrite=1, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - TRAP: all 0.
- Transitions:
  - FETCH->DECODE when mem_ready=1, else hold.
  - DECODE by opcode: 0x23 lw and 0x2B sw -> MEMADDR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x02 -> JUMP; any other -> TRAP.
  - MEMADDR -> MEMREAD (lw) or MEMWRITE (sw), using the held opcode.
  - MEMREAD -> MEMWB on mem_ready, else hold.
  - MEMWRITE -> FETCH on mem_ready, else hold.
  - MEMWB, RWB, BRANCH, JUMP -> FETCH.
  - EXECUTE -> RWB.
  - TRAP holds until reset.
- Latency with no wait states: lw 5 cycles, sw 4, R-type 4, beq 3, j 3. Each mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- retire=1 in: MEMWB, RWB, BRANCH, JUMP, and MEMWRITE when mem_ready=1. Never in TRAP.
- instr_count increments on retire. It wraps from all-ones to 0.
- Timeout:
  - wait_cnt increments each cycle a memory state sees mem_ready=0.
  - wait_cnt clears on any state change or when mem_ready=1.
  - If mem_ready=0 and wait_cnt==MAX_WAIT-1, next state is TRAP and mem_timeout sets.
  - If mem_ready=1 in that same cycle, the transition proceeds normally (ready wins).
- Illegal opcode trap: mem_timeout stays 0.
- Reset asserted mid-instruction aborts it: no retire, counters cleared.
- zero is sampled only in BRANCH. pc_en=1 there iff zero=1.

Test Plan:
- Reset high for 2 cycles, release, mem_ready=1 tied, opcode=0x23 -> states 0,1,2,3,4,0. retire=1 only in MEMWB; instr_count=1. Control values in FETCH match the table (MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01).
- Sequence sw (0x2B), R-type (0x00), j (0x02), mem_ready=1 -> state traces 0,1,2,5 / 0,1,6,7 / 0,1,9. instr_count=3 after 11 cycles; in JUMP PCSource=10 and pc_en=1.
- beq (0x04) with zero=1, then with zero=0 -> pc_en=1 vs 0 in BRANCH. retire=1 in both cases; each takes 3 cycles.
- lw with mem_ready held low 3 cycles in FETCH and 2 in MEMREAD, MAX_WAIT=8 -> IRWrite/PCWrite stay 0 until the ready cycle. Total 10 cycles; retire once.
- mem_ready stuck low in MEMWRITE, MAX_WAIT=8 -> after 8 low cycles state=10, trapped=1, mem_timeout=1, no retire. Repeat with mem_ready rising on the 8th cycle -> FETCH, no trap.
- opcode=0x3F in DECODE -> TRAP, trapped=1, mem_timeout=0. Async reset mid-EXECUTE -> outputs 0 immediately, state=0, instr_count=0.
